// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding, load-use and mul/div hazard detection for the ID stage.
// Optional build macro FWD_STALL_COUNT_EN adds the STALL_CYCLES counter output.
module forwarding_hazard_unit #(
    parameter int XLEN         = 32,
    parameter int NUM_SRC      = 2,
    parameter int MDIV_TIMEOUT = 34
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_SRC*5-1:0]    ID_RS_ADDR,
    input  logic                    ID_VALID,
    input  logic [4:0]              EX_RD_ADDR,
    input  logic                    EX_WRITE_EN,
    input  logic                    EX_MEM_READ,
    input  logic                    EX_MDIV,
    input  logic [4:0]              MEM_RD_ADDR,
    input  logic                    MEM_WRITE_EN,
    input  logic [XLEN-1:0]         MEM_RD_DATA,
    input  logic [4:0]              WB_RD_ADDR,
    input  logic                    WB_WRITE_EN,
    input  logic [XLEN-1:0]         WB_RD_DATA,
    input  logic                    MDIV_DONE,
    output logic [NUM_SRC-1:0]      FORWARD_EN,
    output logic [NUM_SRC*XLEN-1:0] FORWARD_DATA,
    output logic                    STALL,
    output logic                    MDIV_ERR
`ifdef FWD_STALL_COUNT_EN
    ,
    output logic [31:0]             STALL_CYCLES
`endif
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] MDIV_BUSY = 1'b1;
    localparam logic [5:0] BCNT_MAX  = 6'(MDIV_TIMEOUT);

    logic [0:0] state;
    logic [4:0] pend_rd;
    logic [5:0] bcnt;
    logic [5:0] bcnt_inc;
    logic       mdiv_start;
    logic       busy;
    logic       load_use;
    logic       pend_hit;
    logic [4:0] rs;

    function automatic logic [5:0] sat_inc_bcnt(input logic [5:0] v);
        return (v >= BCNT_MAX) ? BCNT_MAX : v + 6'd1;
    endfunction

    assign mdiv_start = EX_MDIV && EX_WRITE_EN && (EX_RD_ADDR != 5'd0);
    assign busy       = (state == MDIV_BUSY);
    assign bcnt_inc   = sat_inc_bcnt(bcnt);

    always_comb begin
        FORWARD_EN   = '0;
        FORWARD_DATA = '0;
        load_use     = 1'b0;
        pend_hit     = 1'b0;
        rs           = 5'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs = ID_RS_ADDR[5*i +: 5];
            // x0 is hardwired zero: never forwarded, never a hazard
            if (rs != 5'd0) begin
                if (MEM_WRITE_EN && (MEM_RD_ADDR == rs)) begin
                    FORWARD_EN[i]                 = 1'b1;
                    FORWARD_DATA[i*XLEN +: XLEN] = MEM_RD_DATA;
                end else if (WB_WRITE_EN && (WB_RD_ADDR == rs)) begin
                    FORWARD_EN[i]                 = 1'b1;
                    FORWARD_DATA[i*XLEN +: XLEN] = WB_RD_DATA;
                end
                if (EX_MEM_READ && EX_WRITE_EN && (EX_RD_ADDR == rs))
                    load_use = 1'b1;
                if (rs == pend_rd)
                    pend_hit = 1'b1;
            end
        end
    end

    // Busy terms vanish during reset because state is forced to IDLE.
    assign STALL = (ID_VALID && load_use)
                 | (busy && ID_VALID && pend_hit)
                 | (busy && EX_MDIV && !MDIV_DONE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            pend_rd  <= 5'd0;
            bcnt     <= 6'd0;
            MDIV_ERR <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdiv_start) begin
                        state   <= MDIV_BUSY;
                        pend_rd <= EX_RD_ADDR;
                        bcnt    <= 6'd0;
                    end
                end
                MDIV_BUSY: begin
                    if (MDIV_DONE) begin
                        if (mdiv_start) begin
                            pend_rd <= EX_RD_ADDR;
                            bcnt    <= 6'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bcnt <= bcnt_inc;
                        if (bcnt_inc == BCNT_MAX) begin
                            MDIV_ERR <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FWD_STALL_COUNT_EN
    function automatic logic [31:0] sat_inc_cnt(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            STALL_CYCLES <= 32'd0;
        else if (STALL)
            STALL_CYCLES <= sat_inc_cnt(STALL_CYCLES);
    end
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: forwarding, load-use, mul/div FSM, timeout, reset.
// Define FWD_STALL_COUNT_EN to also exercise the STALL_CYCLES counter.
module tb_forwarding_hazard_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [9:0]  ID_RS_ADDR;
    logic        ID_VALID;
    logic [4:0]  EX_RD_ADDR;
    logic        EX_WRITE_EN;
    logic        EX_MEM_READ;
    logic        EX_MDIV;
    logic [4:0]  MEM_RD_ADDR;
    logic        MEM_WRITE_EN;
    logic [31:0] MEM_RD_DATA;
    logic [4:0]  WB_RD_ADDR;
    logic        WB_WRITE_EN;
    logic [31:0] WB_RD_DATA;
    logic        MDIV_DONE;
    logic [1:0]  FORWARD_EN;
    logic [63:0] FORWARD_DATA;
    logic        STALL;
    logic        MDIV_ERR;
`ifdef FWD_STALL_COUNT_EN
    logic [31:0] STALL_CYCLES;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    forwarding_hazard_unit #(.XLEN(32), .NUM_SRC(2), .MDIV_TIMEOUT(34)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ID_RS_ADDR   (ID_RS_ADDR),
        .ID_VALID     (ID_VALID),
        .EX_RD_ADDR   (EX_RD_ADDR),
        .EX_WRITE_EN  (EX_WRITE_EN),
        .EX_MEM_READ  (EX_MEM_READ),
        .EX_MDIV      (EX_MDIV),
        .MEM_RD_ADDR  (MEM_RD_ADDR),
        .MEM_WRITE_EN (MEM_WRITE_EN),
        .MEM_RD_DATA  (MEM_RD_DATA),
        .WB_RD_ADDR   (WB_RD_ADDR),
        .WB_WRITE_EN  (WB_WRITE_EN),
        .WB_RD_DATA   (WB_RD_DATA),
        .MDIV_DONE    (MDIV_DONE),
        .FORWARD_EN   (FORWARD_EN),
        .FORWARD_DATA (FORWARD_DATA),
        .STALL        (STALL),
        .MDIV_ERR     (MDIV_ERR)
`ifdef FWD_STALL_COUNT_EN
        ,
        .STALL_CYCLES (STALL_CYCLES)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ID_RS_ADDR   = '0;
        ID_VALID     = 1'b0;
        EX_RD_ADDR   = '0;
        EX_WRITE_EN  = 1'b0;
        EX_MEM_READ  = 1'b0;
        EX_MDIV      = 1'b0;
        MEM_RD_ADDR  = '0;
        MEM_WRITE_EN = 1'b0;
        MEM_RD_DATA  = '0;
        WB_RD_ADDR   = '0;
        WB_WRITE_EN  = 1'b0;
        WB_RD_DATA   = '0;
        MDIV_DONE    = 1'b0;
    endtask

    task automatic set_rs(input logic [4:0] rs1, input logic [4:0] rs0);
        ID_RS_ADDR = {rs1, rs0};
    endtask

    initial begin
        clear_inputs();
        RESET = 1'b1;
        #2;
        check("rst_stall", 64'(STALL), 64'd0);
        check("rst_err", 64'(MDIV_ERR), 64'd0);
        check("rst_fwd_en", 64'(FORWARD_EN), 64'd0);
        step();
        step();
        RESET = 1'b0;

        // MEM priority over WB; rs1=x0 with MEM writing x0
        set_rs(5'd0, 5'd5);
        MEM_RD_ADDR = 5'd5; MEM_WRITE_EN = 1'b1; MEM_RD_DATA = 32'h5555_5555;
        WB_RD_ADDR  = 5'd5; WB_WRITE_EN  = 1'b1; WB_RD_DATA  = 32'hAAAA_AAAA;
        #1;
        check("mem_prio_en0", 64'(FORWARD_EN[0]), 64'd1);
        check("mem_prio_data0", 64'(FORWARD_DATA[31:0]), 64'h5555_5555);
        MEM_RD_ADDR = 5'd0;
        ID_VALID = 1'b1;
        #1;
        check("x0_en1", 64'(FORWARD_EN[1]), 64'd0);
        check("x0_stall", 64'(STALL), 64'd0);
        check("wb_only_data0", 64'(FORWARD_DATA[31:0]), 64'hAAAA_AAAA);
        set_rs(5'd5, 5'd6);
        MEM_RD_ADDR = 5'd6;
        MEM_WRITE_EN = 1'b0;
        #1;
        check("wb_data1", 64'(FORWARD_DATA[63:32]), 64'hAAAA_AAAA);
        check("nomatch_en0", 64'(FORWARD_EN[0]), 64'd0);
        check("nomatch_data0", 64'(FORWARD_DATA[31:0]), 64'd0);

        // Load-use hazard on rs1
        clear_inputs();
        step();
        set_rs(5'd7, 5'd3);
        EX_RD_ADDR = 5'd7; EX_WRITE_EN = 1'b1; EX_MEM_READ = 1'b1;
        #1;
        check("lu_no_valid", 64'(STALL), 64'd0);
        ID_VALID = 1'b1;
        #1;
        check("lu_stall", 64'(STALL), 64'd1);
        step();
        EX_MEM_READ = 1'b0; EX_WRITE_EN = 1'b0; EX_RD_ADDR = 5'd0;
        MEM_RD_ADDR = 5'd7; MEM_WRITE_EN = 1'b1; MEM_RD_DATA = 32'h0000_0077;
        #1;
        check("lu_bubble_stall", 64'(STALL), 64'd0);
        check("lu_fwd_en1", 64'(FORWARD_EN[1]), 64'd1);
        check("lu_fwd_data1", 64'(FORWARD_DATA[63:32]), 64'h77);
        set_rs(5'd0, 5'd0);
        EX_RD_ADDR = 5'd0; EX_WRITE_EN = 1'b1; EX_MEM_READ = 1'b1;
        #1;
        check("lu_x0_stall", 64'(STALL), 64'd0);

        // Mul/div busy: RAW stall, structural stall, done
        clear_inputs();
        step();
        ID_VALID = 1'b1;
        set_rs(5'd0, 5'd9);
        EX_RD_ADDR = 5'd9; EX_WRITE_EN = 1'b1; EX_MDIV = 1'b1;
        #1;
        check("md_idle_start_stall", 64'(STALL), 64'd0);
        step();
        EX_MDIV = 1'b0; EX_WRITE_EN = 1'b0; EX_RD_ADDR = 5'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("md_raw_stall", 64'(STALL), 64'd1);
            step();
        end
        set_rs(5'd0, 5'd10);
        #1;
        check("md_other_reg", 64'(STALL), 64'd0);
        EX_MDIV = 1'b1;
        #1;
        check("md_structural", 64'(STALL), 64'd1);
        EX_MDIV = 1'b0;
        set_rs(5'd0, 5'd9);
        MDIV_DONE = 1'b1;
        #1;
        check("md_done_still_busy", 64'(STALL), 64'd1);
        step();
        MDIV_DONE = 1'b0;
        #1;
        check("md_after_done", 64'(STALL), 64'd0);

        // Back-to-back mul/div: done and new start in the same cycle
        EX_RD_ADDR = 5'd9; EX_WRITE_EN = 1'b1; EX_MDIV = 1'b1;
        set_rs(5'd0, 5'd0);
        step();
        EX_RD_ADDR = 5'd12; MDIV_DONE = 1'b1;
        #1;
        check("b2b_no_struct", 64'(STALL), 64'd0);
        step();
        clear_inputs();
        ID_VALID = 1'b1;
        set_rs(5'd12, 5'd0);
        #1;
        check("b2b_new_pend", 64'(STALL), 64'd1);
        set_rs(5'd9, 5'd0);
        #1;
        check("b2b_old_pend", 64'(STALL), 64'd0);
        MDIV_DONE = 1'b1;
        step();
        MDIV_DONE = 1'b0;
        step();
        MDIV_DONE = 1'b1;
        step();
        MDIV_DONE = 1'b0;
        set_rs(5'd9, 5'd12);
        #1;
        check("done_in_idle", 64'(STALL), 64'd0);

        // Timeout with MDIV_DONE never arriving
        EX_RD_ADDR = 5'd9; EX_WRITE_EN = 1'b1; EX_MDIV = 1'b1;
        set_rs(5'd0, 5'd0);
        step();
        clear_inputs();
        ID_VALID = 1'b1;
        set_rs(5'd0, 5'd9);
        for (int k = 0; k < 33; k++) step();
        check("to_err_before", 64'(MDIV_ERR), 64'd0);
        check("to_stall_before", 64'(STALL), 64'd1);
        step();
        check("to_err_set", 64'(MDIV_ERR), 64'd1);
        check("to_idle", 64'(STALL), 64'd0);
        EX_RD_ADDR = 5'd9; EX_WRITE_EN = 1'b1; EX_MDIV = 1'b1;
        set_rs(5'd0, 5'd0);
        step();
        EX_MDIV = 1'b0; EX_WRITE_EN = 1'b0; EX_RD_ADDR = 5'd0;
        set_rs(5'd0, 5'd9);
        step();
        check("to_err_sticky", 64'(MDIV_ERR), 64'd1);
        check("busy_again", 64'(STALL), 64'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("async_rst_err", 64'(MDIV_ERR), 64'd0);
        check("async_rst_stall", 64'(STALL), 64'd0);

        // Behaviour while reset is held
        EX_RD_ADDR = 5'd4; EX_WRITE_EN = 1'b1; EX_MEM_READ = 1'b1;
        set_rs(5'd0, 5'd4);
        MEM_RD_ADDR = 5'd4; MEM_WRITE_EN = 1'b1; MEM_RD_DATA = 32'h0000_0044;
        #1;
        check("rst_lu_stall", 64'(STALL), 64'd1);
        check("rst_fwd_data0", 64'(FORWARD_DATA[31:0]), 64'h44);
        clear_inputs();
        step();
        RESET = 1'b0;

`ifdef FWD_STALL_COUNT_EN
        check("cnt_after_rst", 64'(STALL_CYCLES), 64'd0);
        ID_VALID = 1'b1;
        set_rs(5'd0, 5'd7);
        EX_RD_ADDR = 5'd7; EX_WRITE_EN = 1'b1; EX_MEM_READ = 1'b1;
        for (int k = 0; k < 4; k++) step();
        EX_MEM_READ = 1'b0; EX_MDIV = 1'b1; EX_RD_ADDR = 5'd9;
        set_rs(5'd0, 5'd0);
        step();
        EX_MDIV = 1'b0; EX_WRITE_EN = 1'b0; EX_RD_ADDR = 5'd0;
        set_rs(5'd0, 5'd9);
        for (int k = 0; k < 3; k++) step();
        set_rs(5'd0, 5'd0);
        MDIV_DONE = 1'b1;
        step();
        MDIV_DONE = 1'b0;
        step();
        check("cnt_seven", 64'(STALL_CYCLES), 64'd7);
        #2;
        RESET = 1'b1;
        #1;
        check("cnt_rst", 64'(STALL_CYCLES), 64'd0);
        step();
        RESET = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/forwarding_hazard_unit.md
FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

Interface
REQ-001 Parameter XLEN, 32, operand data width.
REQ-002 Parameter NUM_SRC, 2, number of ID-stage source operands handled.
REQ-003 Parameter MDIV_TIMEOUT, 34, maximum mul/div busy cycles before error.
REQ-004 CLK  input  1  single clock, rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 ID_RS_ADDR  input  NUM_SRC*5  packed source register addresses of ID instruction; operand i at bits [5i+4:5i].
REQ-007 ID_VALID  input  1  ID instruction valid.
REQ-008 EX_RD_ADDR, EX_WRITE_EN, EX_MEM_READ, EX_MDIV  input  5/1/1/1  EX-stage destination, writes rd, is a load, is a mul/div start.
REQ-009 MEM_RD_ADDR, MEM_WRITE_EN, MEM_RD_DATA  input  5/1/XLEN  MEM-stage destination and result.
REQ-010 WB_RD_ADDR, WB_WRITE_EN, WB_RD_DATA  input  5/1/XLEN  WB-stage destination and result.
REQ-011 MDIV_DONE  input  1  mul/div unit result-ready pulse.
REQ-012 FORWARD_EN  output  NUM_SRC  per-operand forward valid.
REQ-013 FORWARD_DATA  output  NUM_SRC*XLEN  per-operand forwarded value, packed as ID_RS_ADDR.
REQ-014 STALL  output  1  hold IF/ID, bubble into EX.
REQ-015 MDIV_ERR  output  1  sticky mul/div timeout flag.

Function
REQ-016 Forwarding is combinational, zero latency: operand i matches MEM when MEM_WRITE_EN and MEM_RD_ADDR==rs_i and rs_i!=0; likewise WB.
REQ-017 MEM match has priority over WB match; FORWARD_DATA_i = MEM_RD_DATA, else WB_RD_DATA, else 0; FORWARD_EN_i set on either match.
REQ-018 Register x0 is never forwarded and never causes a stall.
REQ-019 Load-use hazard: ID_VALID and EX_MEM_READ and EX_WRITE_EN and EX_RD_ADDR==rs_i!=0 for any i asserts STALL combinationally that cycle.
REQ-020 FSM states IDLE, MDIV_BUSY; registered state, pending rd PEND_RD (5 bits), busy counter BCNT (6 bits).
REQ-021 IDLE -> MDIV_BUSY on clock edge with EX_MDIV and EX_WRITE_EN and EX_RD_ADDR!=0; PEND_RD <= EX_RD_ADDR, BCNT <= 0.
REQ-022 MDIV_BUSY: BCNT increments each cycle, saturating at MDIV_TIMEOUT; STALL asserted while ID_VALID and any rs_i==PEND_RD.
REQ-023 MDIV_BUSY -> IDLE on MDIV_DONE; if EX_MDIV qualifies the same cycle, stay MDIV_BUSY, reload PEND_RD and clear BCNT.
REQ-024 EX_MDIV while MDIV_BUSY without MDIV_DONE asserts STALL (structural hazard); PEND_RD unchanged.
REQ-025 BCNT reaching MDIV_TIMEOUT sets MDIV_ERR and returns FSM to IDLE; MDIV_ERR holds until reset.
REQ-026 MDIV_DONE in IDLE is ignored.
REQ-027 STALL is the OR of all stall sources; forwarding outputs remain valid during STALL.

Reset
REQ-028 RESET asserted at any time forces state IDLE, PEND_RD=0, BCNT=0, MDIV_ERR=0 immediately, without waiting for CLK.
REQ-029 During reset STALL reflects only the combinational load-use term; FORWARD_EN/FORWARD_DATA follow inputs.

Configuration
REQ-030 Macro FWD_STALL_COUNT_EN defined: adds output STALL_CYCLES (32-bit) counting cycles with STALL=1, saturating at 0xFFFFFFFF, cleared by RESET.
REQ-031 Macro undefined: no STALL_CYCLES port, no counter logic; all other behaviour identical.

Verification
REQ-032 rs0=5, MEM rd=5 WE=1 data 0x55555555, WB rd=5 WE=1 data 0xAAAAAAAA -> FORWARD_EN[0]=1, FORWARD_DATA_0=0x55555555 (MEM priority).
REQ-033 rs1=0, MEM rd=0 WE=1 -> FORWARD_EN[1]=0, STALL=0.
REQ-034 EX load rd=7, ID rs1=7 ID_VALID=1 -> STALL=1 same cycle; next cycle EX bubble (EX_MEM_READ=0) -> STALL=0, MEM forwards rd 7.
REQ-035 EX_MDIV rd=9; following 3 cycles ID rs0=9 -> STALL=1; MDIV_DONE pulse -> IDLE next edge, STALL=0.
REQ-036 EX_MDIV rd=9, MDIV_DONE never -> MDIV_ERR=1 after 34 cycles, FSM IDLE; RESET mid-busy -> MDIV_ERR=0, STALL=0 immediately.
REQ-037 With FWD_STALL_COUNT_EN: 4 load-use plus 3 mul/div stall cycles -> STALL_CYCLES=7; RESET -> 0.
